// File: rtl/tmds_channel_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tmds_channel_decoder
// Description : Receive side of one DVI/TMDS channel. Takes 10-bit words from
//               an external 1:10 deserializer, bit-slips until a steady run
//               of control tokens is seen, then decodes TMDS data/control
//               symbols into pixel data, c0/c1 and DE.
// Ports       : clk      - pixel clock, rising edge
//               rst      - synchronous reset, active-high
//               in_word  - raw deserialized bits, bit 0 received first
//               data_out - decoded pixel byte (valid when de=1)
//               c0, c1   - control bits from the last control token
//               de       - 1 = data period, 0 = control period
//               locked   - symbol alignment achieved
//               slip     - current bit offset, 0..9
// Revision    : 1.0 - initial release
// ============================================================================
module tmds_channel_decoder #(
    parameter int LOCK_TOKENS   = 16,
    parameter int SEARCH_WINDOW = 256,
    parameter int LOSS_TIMEOUT  = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] in_word,
    output logic [7:0] data_out,
    output logic       c0,
    output logic       c1,
    output logic       de,
    output logic       locked,
    output logic [3:0] slip
);

    localparam int c_RUN_W = $clog2(LOCK_TOKENS + 1);
    localparam int c_WIN_W = $clog2(SEARCH_WINDOW);
    localparam int c_GAP_W = $clog2(LOSS_TIMEOUT);

    localparam logic [c_RUN_W-1:0] c_RUN_MAX  = c_RUN_W'(LOCK_TOKENS);
    localparam logic [c_RUN_W-1:0] c_RUN_ONE  = c_RUN_W'(1);
    localparam logic [c_WIN_W-1:0] c_WIN_LAST = c_WIN_W'(SEARCH_WINDOW - 1);
    localparam logic [c_WIN_W-1:0] c_WIN_ONE  = c_WIN_W'(1);
    localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'(LOSS_TIMEOUT - 1);
    localparam logic [c_GAP_W-1:0] c_GAP_ONE  = c_GAP_W'(1);

    localparam logic [9:0] c_TOK_00 = 10'b1101010100;
    localparam logic [9:0] c_TOK_01 = 10'b0010101011;
    localparam logic [9:0] c_TOK_10 = 10'b0101010100;
    localparam logic [9:0] c_TOK_11 = 10'b1010101011;

    localparam logic [1:0] c_SETTLE_CYCLES = 2'd2;
    localparam logic [3:0] c_SLIP_LAST     = 4'd9;

    typedef enum logic [0:0] {
        ST_SEARCH = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t             state_q,    state_d;
    logic [9:0]         prev_word_q;
    logic [9:0]         aligned_q,  aligned_d;
    logic [3:0]         slip_q,     slip_d;
    logic [c_RUN_W-1:0] run_cnt_q,  run_cnt_d;
    logic [c_WIN_W-1:0] win_cnt_q,  win_cnt_d;
    logic [c_GAP_W-1:0] gap_cnt_q,  gap_cnt_d;
    logic [1:0]         settle_q,   settle_d;
    logic [7:0]         data_q,     data_d;
    logic               c0_q,       c0_d;
    logic               c1_q,       c1_d;
    logic               de_q,       de_d;

    logic [19:0]        w_pair;
    logic               w_is_ctrl;
    logic               w_ctrl_valid;
    logic [1:0]         w_tok_c;
    logic [7:0]         w_d;
    logic [7:0]         w_decoded;
    logic [c_RUN_W-1:0] w_run_next;

    // Older word in the low half so a larger slip looks later in the stream.
    assign w_pair    = {in_word, prev_word_q};
    assign aligned_d = w_pair[{1'b0, slip_q} +: 10];

    always_comb begin
        w_is_ctrl = 1'b1;
        w_tok_c   = 2'b00;
        case (aligned_q)
            c_TOK_00: w_tok_c = 2'b00;
            c_TOK_01: w_tok_c = 2'b01;
            c_TOK_10: w_tok_c = 2'b10;
            c_TOK_11: w_tok_c = 2'b11;
            default:  w_is_ctrl = 1'b0;
        endcase
    end

    // Right after a slip change aligned_q still holds a word taken at the old
    // offset; the settle counter keeps such words out of the lock decision.
    assign w_ctrl_valid = w_is_ctrl && (settle_q == 2'd0);

    always_comb begin
        w_d          = aligned_q[9] ? ~aligned_q[7:0] : aligned_q[7:0];
        w_decoded    = 8'h00;
        w_decoded[0] = w_d[0];
        for (int i = 1; i < 8; i++) begin
            w_decoded[i] = aligned_q[8] ? (w_d[i] ^ w_d[i-1]) : ~(w_d[i] ^ w_d[i-1]);
        end
    end

    assign w_run_next = w_ctrl_valid
                      ? ((run_cnt_q == c_RUN_MAX) ? run_cnt_q : run_cnt_q + c_RUN_ONE)
                      : '0;

    // Alignment state machine: next state and counters.
    always_comb begin
        state_d   = state_q;
        slip_d    = slip_q;
        run_cnt_d = run_cnt_q;
        win_cnt_d = win_cnt_q;
        gap_cnt_d = gap_cnt_q;
        settle_d  = (settle_q != 2'd0) ? settle_q - 2'd1 : 2'd0;

        case (state_q)
            ST_SEARCH: begin
                gap_cnt_d = '0;
                run_cnt_d = w_run_next;
                if (w_run_next == c_RUN_MAX) begin
                    // Lock takes priority over a window expiring this cycle.
                    state_d   = ST_LOCKED;
                    run_cnt_d = '0;
                    win_cnt_d = '0;
                end else if (win_cnt_q == c_WIN_LAST) begin
                    slip_d    = (slip_q == c_SLIP_LAST) ? 4'd0 : slip_q + 4'd1;
                    run_cnt_d = '0;
                    win_cnt_d = '0;
                    settle_d  = c_SETTLE_CYCLES;
                end else begin
                    win_cnt_d = win_cnt_q + c_WIN_ONE;
                end
            end
            ST_LOCKED: begin
                if (w_ctrl_valid) begin
                    gap_cnt_d = '0;
                end else if (gap_cnt_q == c_GAP_LAST) begin
                    // Keep slip: re-search begins at the last good offset.
                    state_d   = ST_SEARCH;
                    gap_cnt_d = '0;
                    run_cnt_d = '0;
                    win_cnt_d = '0;
                    settle_d  = 2'd0;
                end else begin
                    gap_cnt_d = gap_cnt_q + c_GAP_ONE;
                end
            end
            default: begin
                state_d = ST_SEARCH;
            end
        endcase
    end

    // Outputs follow the next state so locked and de change on the same edge.
    always_comb begin
        data_d = 8'h00;
        c0_d   = 1'b0;
        c1_d   = 1'b0;
        de_d   = 1'b0;
        if (state_d == ST_LOCKED) begin
            if (w_is_ctrl) begin
                c0_d = w_tok_c[0];
                c1_d = w_tok_c[1];
            end else begin
                de_d   = 1'b1;
                data_d = w_decoded;
                c0_d   = c0_q;
                c1_d   = c1_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_SEARCH;
            prev_word_q <= '0;
            aligned_q   <= '0;
            slip_q      <= '0;
            run_cnt_q   <= '0;
            win_cnt_q   <= '0;
            gap_cnt_q   <= '0;
            settle_q    <= '0;
            data_q      <= '0;
            c0_q        <= 1'b0;
            c1_q        <= 1'b0;
            de_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_word_q <= in_word;
            aligned_q   <= aligned_d;
            slip_q      <= slip_d;
            run_cnt_q   <= run_cnt_d;
            win_cnt_q   <= win_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            settle_q    <= settle_d;
            data_q      <= data_d;
            c0_q        <= c0_d;
            c1_q        <= c1_d;
            de_q        <= de_d;
        end
    end

    assign data_out = data_q;
    assign c0       = c0_q;
    assign c1       = c1_q;
    assign de       = de_q;
    assign locked   = (state_q == ST_LOCKED);
    assign slip     = slip_q;

endmodule
`default_nettype wire

// File: tb/tb_tmds_channel_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_tmds_channel_decoder
// Description : Self-checking bench for tmds_channel_decoder. A bit-stream
//               level reference model predicts every output each cycle;
//               directed checks cover lock, slip search, decode, control
//               tokens, loss of lock and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tmds_channel_decoder;

    localparam int LOCK_TOKENS   = 16;
    localparam int SEARCH_WINDOW = 256;
    localparam int LOSS_TIMEOUT  = 4096;

    localparam logic [9:0] T00 = 10'b1101010100;
    localparam logic [9:0] T01 = 10'b0010101011;
    localparam logic [9:0] T10 = 10'b0101010100;
    localparam logic [9:0] T11 = 10'b1010101011;
    localparam logic [9:0] D00 = 10'b0100000000;
    localparam logic [9:0] DFE = 10'b1011111111;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] in_word;
    logic [7:0] data_out;
    logic       c0, c1, de, locked;
    logic [3:0] slip;

    tmds_channel_decoder #(
        .LOCK_TOKENS  (LOCK_TOKENS),
        .SEARCH_WINDOW(SEARCH_WINDOW),
        .LOSS_TIMEOUT (LOSS_TIMEOUT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .in_word (in_word),
        .data_out(data_out),
        .c0      (c0),
        .c1      (c1),
        .de      (de),
        .locked  (locked),
        .slip    (slip)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state.
    logic [9:0] tok [4];
    logic [9:0] m_prev, m_al;
    int         m_slip, m_run, m_win, m_gap, m_settle;
    bit         m_locked, m_c0, m_c1, m_de;
    logic [7:0] m_data;

    function automatic logic [7:0] tmds_byte(input logic [9:0] q);
        logic [7:0] d, r;
        d    = q[9] ? ~q[7:0] : q[7:0];
        r    = 8'h00;
        r[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            r[i] = q[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        end
        return r;
    endfunction

    function automatic logic [9:0] rotl10(input logic [9:0] w, input int k);
        logic [19:0] t;
        t = {w, w} << k;
        return t[19:10];
    endfunction

    task automatic model_step(input bit r, input logic [9:0] w);
        int idx, settle_nx, old_slip, pair;
        bit valid;
        if (r) begin
            m_prev = '0; m_al = '0; m_slip = 0; m_run = 0; m_win = 0; m_gap = 0;
            m_settle = 0; m_locked = 0; m_data = '0; m_c0 = 0; m_c1 = 0; m_de = 0;
            return;
        end
        idx = -1;
        for (int t = 0; t < 4; t++) if (m_al == tok[t]) idx = t;
        valid     = (idx >= 0) && (m_settle == 0);
        settle_nx = (m_settle > 0) ? m_settle - 1 : 0;
        old_slip  = m_slip;
        if (!m_locked) begin
            m_run = valid ? ((m_run < LOCK_TOKENS) ? m_run + 1 : m_run) : 0;
            if (m_run == LOCK_TOKENS) begin
                m_locked = 1; m_run = 0; m_win = 0;
            end else if (m_win == SEARCH_WINDOW - 1) begin
                m_slip = (m_slip + 1) % 10; m_run = 0; m_win = 0; settle_nx = 2;
            end else begin
                m_win++;
            end
        end else begin
            if (valid) m_gap = 0;
            else if (m_gap + 1 == LOSS_TIMEOUT) begin
                m_locked = 0; m_gap = 0; m_run = 0; m_win = 0; settle_nx = 0;
            end else m_gap++;
        end
        m_settle = settle_nx;
        if (!m_locked) begin
            m_de = 0; m_data = '0; m_c0 = 0; m_c1 = 0;
        end else if (idx >= 0) begin
            m_de = 0; m_data = '0; m_c0 = idx[0]; m_c1 = idx[1];
        end else begin
            m_de = 1; m_data = tmds_byte(m_al);
        end
        pair   = (int'(w) << 10) | int'(m_prev);
        m_al   = 10'((pair >> old_slip) & 1023);
        m_prev = w;
    endtask

    task automatic check16(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input logic [9:0] w);
        in_word = w;
        @(posedge clk);
        model_step(rst, w);
        #1;
        check16("model", {data_out, c1, c0, de, locked, slip},
                {m_data, m_c1, m_c0, m_de, m_locked, 4'(m_slip)});
    endtask

    initial begin
        int max_slip, k, limit;
        tok[0] = T00; tok[1] = T01; tok[2] = T10; tok[3] = T11;
        rst = 1'b1;
        in_word = '0;

        // Reset with random input words.
        for (int i = 0; i < 3; i++) tick(10'($urandom));
        check16("reset_state", {data_out, c1, c0, de, locked, slip}, 16'h0000);
        rst = 1'b0;

        // Aligned token stream: lock after 16 tokens plus two cycles.
        for (int i = 0; i < 17; i++) tick(T00);
        check16("pre_lock", {15'd0, locked}, 16'd0);
        tick(T00);
        check16("lock_aligned", {11'd0, locked, slip}, {11'd0, 1'b1, 4'd0});
        check16("lock_ctrl", {13'd0, de, c1, c0}, 16'd0);

        // Data decode, two cycles after presentation.
        tick(D00); tick(DFE); tick(T00);
        check16("data_00", {7'd0, de, data_out}, {7'd0, 1'b1, 8'h00});
        tick(T00);
        check16("data_fe", {7'd0, de, data_out}, {7'd0, 1'b1, 8'hFE});
        tick(T00); tick(T00);

        // Control tokens, then data holds the last control value.
        tick(T01); tick(T10); tick(T11);
        check16("ctrl_01", {13'd0, de, c1, c0}, {13'd0, 3'b001});
        tick(D00);
        check16("ctrl_10", {13'd0, de, c1, c0}, {13'd0, 3'b010});
        tick(T00);
        check16("ctrl_11", {13'd0, de, c1, c0}, {13'd0, 3'b011});
        tick(T00);
        check16("ctrl_hold", {13'd0, de, c1, c0}, {13'd0, 3'b111});
        for (int i = 0; i < 4; i++) tick(T00);

        // Loss of lock after 4096 non-control cycles.
        for (int i = 0; i < LOSS_TIMEOUT + 1; i++) tick(D00);
        check16("still_locked", {15'd0, locked}, 16'd1);
        tick(D00);
        check16("lock_lost", {10'd0, locked, de, slip}, 16'd0);

        // Reset during relock.
        for (int i = 0; i < 10; i++) tick(T00);
        rst = 1'b1;
        tick(T00);
        check16("reset_mid", {data_out, c1, c0, de, locked, slip}, 16'h0000);
        rst = 1'b0;

        // Stream delayed by 3 bits: slip search 0 -> 3.
        max_slip = 0;
        for (int i = 0; i < 4 * SEARCH_WINDOW + 40 && !locked; i++) begin
            tick(rotl10(T00, 3));
            if (int'(slip) > max_slip) max_slip = int'(slip);
        end
        check16("lock_slip3", {11'd0, locked, slip}, {11'd0, 1'b1, 4'd3});
        check16("max_slip3", 16'(max_slip), 16'd3);

        // Random offset, then random traffic.
        rst = 1'b1;
        tick(10'($urandom));
        rst = 1'b0;
        k = $urandom_range(0, 9);
        limit = 10 * SEARCH_WINDOW + 40;
        for (int i = 0; i < limit && !locked; i++) tick(rotl10(T00, k));
        check16("lock_rand", {11'd0, locked, slip}, {11'd0, 1'b1, 4'(k)});
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) tick(rotl10(tok[$urandom_range(0, 3)], k));
            else tick(10'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tmds_channel_decoder.md
Name: tmds_channel_decoder

Overview:
- Receive-side counterpart of the DVI/TMDS transmit path: one instance per TMDS channel.
- Accepts 10-bit parallel words from an external 1:10 deserializer, one word per pixel clock.
- Finds symbol alignment by bit-slipping until control tokens are seen, then decodes TMDS data and control symbols into 8-bit pixel data, c0/c1 and DE.
- Sits between the deserializer and the video capture/pixel pipeline.

Parameters:
- LOCK_TOKENS, 16: consecutive control tokens at one slip offset required to declare lock.
- SEARCH_WINDOW, 256: cycles spent at one slip offset before advancing.
- LOSS_TIMEOUT, 4096: consecutive cycles without any control token, while locked, before lock is dropped.

Ports:
- clk  in  1  pixel clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- in_word  in  10  raw deserialized bits; bit 0 is the earliest received.
- data_out  out  8  decoded pixel byte.
- c0  out  1  control bit 0 (HSYNC on channel 0).
- c1  out  1  control bit 1 (VSYNC on channel 0).
- de  out  1  1 = data_out valid (data period); 0 = control period.
- locked  out  1  alignment achieved.
- slip  out  4  current bit offset, 0..9.

Behaviour:
- Reset (rst=1 at an edge): data_out=0, c0=0, c1=0, de=0, locked=0, slip=0, state=SEARCH. All counters and pipeline registers clear.
- Reset mid-operation: same result, at the next edge.
- Pipeline:
  - prev_word <= in_word.
  - aligned_q <= bits [slip+9:slip] of {in_word, prev_word}.
  - Outputs are registered from aligned_q.
  - At slip=0, a word presented before edge N appears on the outputs after edge N+2.
- Control tokens, written q[9:0]: 1101010100 (c1c0=00), 0010101011 (01), 0101010100 (10), 1010101011 (11). is_ctrl = aligned_q equals one of these.
- Data decode:
  - d = q[9] ? ~q[7:0] : q[7:0].
  - data[0] = d[0].
  - For i=1..7: data[i] = q[8] ? d[i]^d[i-1] : ~(d[i]^d[i-1]).
- Output register update, every cycle:
  - If locked and is_ctrl: de=0, {c1,c0} from the token, data_out=0.
  - If locked and not is_ctrl: de=1, data_out=decoded byte, c0/c1 hold their last values.
  - If not locked: de=0, data_out=0, c0=c1=0.
- State machine, 2 states:
  - SEARCH:
    - run_cnt increments on is_ctrl and clears on a non-ctrl word.
    - win_cnt increments every cycle.
    - run_cnt reaching LOCK_TOKENS: go to LOCKED, set locked=1, keep slip.
    - Otherwise, win_cnt reaching SEARCH_WINDOW-1: slip = (slip==9) ? 0 : slip+1, clear run_cnt and win_cnt.
    - Both conditions on the same cycle: lock wins, slip unchanged.
  - After any slip change, a settle counter masks is_ctrl evaluation for 2 cycles, so aligned_q values computed with the stale offset are ignored. win_cnt still runs.
  - LOCKED:
    - gap_cnt clears on is_ctrl, otherwise increments.
    - gap_cnt reaching LOSS_TIMEOUT: go to SEARCH, locked=0, clear all counters, slip unchanged (re-search starts at the last good offset).
    - locked and de update on the same edge as the state change.
- Width rules:
  - run_cnt saturates at LOCK_TOKENS.
  - gap_cnt and win_cnt are sized by $clog2 of their limits and never wrap.
  - slip wraps 9 -> 0.

Test Plan:
- Reset: hold rst 3 cycles with random in_word -> data_out=0, de=0, c0=c1=0, locked=0, slip=0; release and verify none of these change before lock.
- Aligned stream of token 1101010100 (bit 0 first) -> locked=1 after 16 tokens plus pipeline latency; slip=0, de=0, c0=c1=0.
- Same token stream delayed by 3 bits -> slip steps 1, 2, 3 at 256-cycle intervals; locked=1 with slip=3; slip never exceeds 3.
- After lock, send words 0100000000 then 1011111111 -> data_out=0x00 then 0xFE, de=1, two cycles after presentation.
- After lock, send tokens 0010101011, 0101010100, 1010101011 -> {c1,c0} = 01, 10, 11 on consecutive cycles, de=0. Then send a data word -> c0/c1 hold 11.
- After lock, 4096 consecutive data words 0100000000 -> locked falls on cycle 4096, de=0, slip unchanged. Assert rst during a later relock -> all outputs 0, slip=0 the next cycle.
